lcd_layer_compositor: RTL and testbench

Parametrised LCD timing generator and N-layer window compositor for the RGB565 panel.
- Generates HSYNC/VSYNC/DE and active-area pixel coordinates.
- Holds a runtime-programmable rectangle per layer, double-buffered to frame boundaries.
- Composites layer colours by fixed priority with per-layer colour-key transparency.
- Sits between the per-widget display modules (clock, mode, temp/humi, alarms, title) and the panel pins.

---
 rtl/lcd_layer_compositor_if.sv | 24 ++
 rtl/lcd_layer_compositor.sv | 149 ++++++++++++++
 tb/tb_lcd_layer_compositor.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_layer_compositor_if.sv
// Layer-side bus of the LCD compositor: window writes, per-layer enables and
// colours in, scan coordinates and frame marker out.
interface lcd_layer_compositor_if #(
  parameter int NUM_LAYERS = 8
);
  logic                      win_wr_en;
  logic [3:0]                win_wr_idx;
  logic [47:0]               win_wr_data;
  logic [NUM_LAYERS-1:0]     layer_en;
  logic [16*NUM_LAYERS-1:0]  layer_rgb;
  logic [11:0]               pixel_x;
  logic [11:0]               pixel_y;
  logic                      frame_start;

  modport master (
    output win_wr_en, win_wr_idx, win_wr_data, layer_en, layer_rgb,
    input  pixel_x, pixel_y, frame_start
  );

  modport slave (
    input  win_wr_en, win_wr_idx, win_wr_data, layer_en, layer_rgb,
    output pixel_x, pixel_y, frame_start
  );
endinterface

// File: rtl/lcd_layer_compositor.sv
// RGB565 panel timing generator with N-layer priority window compositor,
// colour-key transparency and frame-synchronous window double buffering.
module lcd_layer_compositor #(
  parameter int                    H_ACTIVE   = 800,
  parameter int                    H_FP       = 210,
  parameter int                    H_PULSE    = 1,
  parameter int                    H_BP       = 182,
  parameter int                    V_ACTIVE   = 480,
  parameter int                    V_FP       = 45,
  parameter int                    V_PULSE    = 5,
  parameter int                    V_BP       = 0,
  parameter int                    NUM_LAYERS = 8,
  parameter logic [15:0]           KEY_COLOR  = 16'hFFFF,
  parameter logic [NUM_LAYERS-1:0] KEY_MASK   = '1,
  parameter logic [15:0]           BG_COLOR   = 16'hFFFF
) (
  input  logic                         PixelClk,
  input  logic                         nRST,
  lcd_layer_compositor_if.slave        lcd_bus,
  output logic                         LCD_DE,
  output logic                         LCD_HSYNC,
  output logic                         LCD_VSYNC,
  output logic [4:0]                   LCD_R,
  output logic [5:0]                   LCD_G,
  output logic [4:0]                   LCD_B
);

  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_PULSE + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_PULSE + V_BP - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_PULSE);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_PULSE);

  logic [11:0]           r_h_cnt;
  logic [11:0]           r_v_cnt;
  logic [47:0]           r_pend [NUM_LAYERS];
  logic [47:0]           r_act  [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] r_hit;
  logic                  r_de1;
  logic                  r_hs1;
  logic                  r_vs1;

  logic                  w_frame_start;
  logic                  w_de_raw;
  logic                  w_hs_raw;
  logic                  w_vs_raw;
  logic [NUM_LAYERS-1:0] w_hit;
  logic [15:0]           w_pix;
  logic                  w_found;

  assign w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_de_raw      = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_raw      = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
  assign w_vs_raw      = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));

  assign lcd_bus.pixel_x     = r_h_cnt;
  assign lcd_bus.pixel_y     = r_v_cnt;
  assign lcd_bus.frame_start = w_frame_start;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 12'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 12'd1;
    end
  end

  // The bank swap reads r_pend before this edge's write lands, so a write
  // coinciding with frame_start only becomes active one frame later.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        r_pend[i] <= '0;
        r_act[i]  <= '0;
      end
    end else begin
      if (w_frame_start) begin
        for (int unsigned i = 0; i < NUM_LAYERS; i++) r_act[i] <= r_pend[i];
      end
      if (lcd_bus.win_wr_en) begin
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
          if (lcd_bus.win_wr_idx == 4'(i)) r_pend[i] <= lcd_bus.win_wr_data;
        end
      end
    end
  end

  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      w_hit[i] = lcd_bus.layer_en[i] &&
                 (r_h_cnt >= r_act[i][47:36]) && (r_h_cnt < r_act[i][35:24]) &&
                 (r_v_cnt >= r_act[i][23:12]) && (r_v_cnt < r_act[i][11:0]);
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_hit <= '0;
      r_de1 <= 1'b0;
      r_hs1 <= 1'b1;
      r_vs1 <= 1'b1;
    end else begin
      r_hit <= w_hit;
      r_de1 <= w_de_raw;
      r_hs1 <= w_hs_raw;
      r_vs1 <= w_vs_raw;
    end
  end

  // Lowest index wins; keyed layers fall through to the next candidate.
  always_comb begin
    w_pix   = BG_COLOR;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!w_found && r_hit[i] &&
          !(KEY_MASK[i] && (lcd_bus.layer_rgb[16*i +: 16] == KEY_COLOR))) begin
        w_pix   = lcd_bus.layer_rgb[16*i +: 16];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      LCD_DE    <= 1'b0;
      LCD_HSYNC <= 1'b1;
      LCD_VSYNC <= 1'b1;
      LCD_R     <= '0;
      LCD_G     <= '0;
      LCD_B     <= '0;
    end else begin
      LCD_DE    <= r_de1;
      LCD_HSYNC <= r_hs1;
      LCD_VSYNC <= r_vs1;
      LCD_R     <= r_de1 ? w_pix[15:11] : '0;
      LCD_G     <= r_de1 ? w_pix[10:5]  : '0;
      LCD_B     <= r_de1 ? w_pix[4:0]   : '0;
    end
  end

endmodule

// File: tb/tb_lcd_layer_compositor.sv
// Bench for lcd_layer_compositor: reduced timing, two instances differing only
// in KEY_MASK, cycle scoreboard of expected panel outputs.
module tb_lcd_layer_compositor;
  localparam int HA = 16, HF = 3, HP = 2, HB = 2, HT = HA + HF + HP + HB;
  localparam int VA = 8,  VF = 2, VP = 1, VB = 1, VT = VA + VF + VP + VB;
  localparam int NL = 4;
  localparam int FRAME = HT * VT;

  logic              clk;
  logic              nrst;
  logic              wr_en;
  logic [3:0]        wr_idx;
  logic [47:0]       wr_data;
  logic [NL-1:0]     en;
  logic [16*NL-1:0]  rgb;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_layer_compositor_if #(.NUM_LAYERS(NL)) ifa ();
  lcd_layer_compositor_if #(.NUM_LAYERS(NL)) ifb ();

  assign ifa.win_wr_en   = wr_en;
  assign ifa.win_wr_idx  = wr_idx;
  assign ifa.win_wr_data = wr_data;
  assign ifa.layer_en    = en;
  assign ifa.layer_rgb   = rgb;
  assign ifb.win_wr_en   = wr_en;
  assign ifb.win_wr_idx  = wr_idx;
  assign ifb.win_wr_data = wr_data;
  assign ifb.layer_en    = en;
  assign ifb.layer_rgb   = rgb;

  logic       a_de, a_hs, a_vs, b_de, b_hs, b_vs;
  logic [4:0] a_r, a_b, b_r, b_b;
  logic [5:0] a_g, b_g;
  logic [18:0] a_out, b_out;
  assign a_out = {a_de, a_hs, a_vs, a_r, a_g, a_b};
  assign b_out = {b_de, b_hs, b_vs, b_r, b_g, b_b};

  lcd_layer_compositor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_PULSE(HP), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_PULSE(VP), .V_BP(VB),
    .NUM_LAYERS(NL), .KEY_COLOR(16'hFFFF), .KEY_MASK(4'b1111), .BG_COLOR(16'hFFFF)
  ) dut_a (
    .PixelClk(clk), .nRST(nrst), .lcd_bus(ifa.slave),
    .LCD_DE(a_de), .LCD_HSYNC(a_hs), .LCD_VSYNC(a_vs),
    .LCD_R(a_r), .LCD_G(a_g), .LCD_B(a_b)
  );

  lcd_layer_compositor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_PULSE(HP), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_PULSE(VP), .V_BP(VB),
    .NUM_LAYERS(NL), .KEY_COLOR(16'hFFFF), .KEY_MASK(4'b1110), .BG_COLOR(16'hFFFF)
  ) dut_b (
    .PixelClk(clk), .nRST(nrst), .lcd_bus(ifb.slave),
    .LCD_DE(b_de), .LCD_HSYNC(b_hs), .LCD_VSYNC(b_vs),
    .LCD_R(b_r), .LCD_G(b_g), .LCD_B(b_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [47:0] win(input int x0, input int x1, input int y0, input int y1);
    return {12'(x0), 12'(x1), 12'(y0), 12'(y1)};
  endfunction

  function automatic logic [18:0] expect_out(input logic [NL-1:0] hit, input logic de,
                                             input logic hs, input logic vs,
                                             input logic [16*NL-1:0] colours,
                                             input logic [NL-1:0] mask);
    logic [15:0] c;
    logic        found;
    c = 16'hFFFF;
    found = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (!found && hit[i] && !(mask[i] && colours[16*i +: 16] == 16'hFFFF)) begin
        c = colours[16*i +: 16];
        found = 1'b1;
      end
    end
    if (!de) c = 16'h0000;
    return {de, hs, vs, c};
  endfunction

  typedef struct {
    logic [18:0] a;
    logic [18:0] b;
  } exp_t;

  exp_t        sb[$];
  int          m_h = 0;
  int          m_v = 0;
  logic [47:0] m_pend [NL];
  logic [47:0] m_act  [NL];
  logic [NL-1:0] m_hit;
  logic        m_de1, m_hs1, m_vs1;

  // Reference model: advances once per cycle at the negative edge.
  always @(negedge clk) begin
    exp_t e;
    logic [11:0] h12, v12;
    if (!nrst) begin
      check("reset_out_a", 32'(a_out), 32'({1'b0, 1'b1, 1'b1, 16'h0000}));
      check("reset_out_b", 32'(b_out), 32'({1'b0, 1'b1, 1'b1, 16'h0000}));
      check("reset_coord", 32'({ifa.pixel_x, ifa.pixel_y, ifa.frame_start}), 32'({12'd0, 12'd0, 1'b1}));
      sb.delete();
      m_h = 0; m_v = 0;
      m_hit = '0; m_de1 = 1'b0; m_hs1 = 1'b1; m_vs1 = 1'b1;
      for (int i = 0; i < NL; i++) begin
        m_pend[i] = '0;
        m_act[i]  = '0;
      end
    end else begin
      h12 = m_h[11:0];
      v12 = m_v[11:0];
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("panel_a", 32'(a_out), 32'(e.a));
        check("panel_b", 32'(b_out), 32'(e.b));
      end
      check("coord", 32'({ifa.pixel_x, ifa.pixel_y, ifa.frame_start}),
            32'({h12, v12, (m_h == 0 && m_v == 0)}));
      e.a = expect_out(m_hit, m_de1, m_hs1, m_vs1, rgb, 4'b1111);
      e.b = expect_out(m_hit, m_de1, m_hs1, m_vs1, rgb, 4'b1110);
      sb.push_back(e);
      for (int i = 0; i < NL; i++) begin
        m_hit[i] = en[i] && h12 >= m_act[i][47:36] && h12 < m_act[i][35:24] &&
                   v12 >= m_act[i][23:12] && v12 < m_act[i][11:0];
      end
      m_de1 = (m_h < HA) && (m_v < VA);
      m_hs1 = !(m_h >= HA + HF && m_h < HA + HF + HP);
      m_vs1 = !(m_v >= VA + VF && m_v < VA + VF + VP);
      if (m_h == 0 && m_v == 0) begin
        for (int i = 0; i < NL; i++) m_act[i] = m_pend[i];
      end
      if (wr_en && wr_idx < 4'(NL)) m_pend[wr_idx[1:0]] = wr_data;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int h, input int v);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(posedge clk);
      #1;
      if (m_h == h && m_v == v) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      $error("FAIL wait_pos observed=timeout expected=(%0d,%0d)", h, v);
    end
  endtask

  task automatic write_win(input logic [3:0] idx, input logic [47:0] data);
    wr_en   = 1'b1;
    wr_idx  = idx;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; en = '0; rgb = '0;
    run(3);
    nrst = 1'b1;
    run(FRAME + 7);

    // single red window on layer 2, written mid-frame
    wait_pos(5, 3);
    en = 4'b0100;
    rgb[47:32] = 16'hF800;
    write_win(4'd2, win(4, 10, 2, 5));
    run(2 * FRAME);

    // overlapping layers: 0 green over 2 red over 3 blue
    write_win(4'd0, win(0, 8, 0, 8));
    write_win(4'd3, win(0, 16, 0, 8));
    rgb[15:0]  = 16'h07E0;
    rgb[63:48] = 16'h001F;
    en = 4'b1101;
    run(2 * FRAME);

    // layer 0 at key colour: transparent in dut_a, white in dut_b
    rgb[15:0] = 16'hFFFF;
    run(FRAME);
    rgb[15:0] = 16'h07E0;

    // mid-frame write then a write in the frame_start cycle
    wait_pos(7, 4);
    en = 4'b1111;
    rgb[31:16] = 16'h1234;
    write_win(4'd1, win(2, 6, 1, 3));
    wait_pos(0, 0);
    write_win(4'd3, win(8, 16, 4, 8));
    run(2 * FRAME + 20);

    // empty windows never hit
    write_win(4'd2, win(10, 4, 0, 8));
    write_win(4'd1, win(3, 3, 0, 8));
    run(2 * FRAME);

    // out-of-range indices are ignored
    write_win(4'd12, win(0, 16, 0, 8));
    write_win(4'd5, win(0, 16, 0, 8));
    run(2 * FRAME);

    // live layer_en change mid-line
    wait_pos(2, 1);
    en = 4'b0000;
    run(5);
    en = 4'b1111;
    run(FRAME);

    // asynchronous reset mid-frame
    wait_pos(10, 5);
    nrst = 1'b0;
    #1;
    check("async_reset_a", 32'(a_out), 32'({1'b0, 1'b1, 1'b1, 16'h0000}));
    check("async_reset_coord", 32'({ifa.pixel_x, ifa.pixel_y}), 32'({12'd0, 12'd0}));
    run(3);
    nrst = 1'b1;
    run(FRAME + 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
